// File: rtl/nic_defs_pkg.sv
// Shared NIC/network definitions used by the ToR switch scheduler.
// Holds the packet word type, destination-ID type and small helpers.
package nic_defs;

  localparam int TOR_MAX_NICS = 8;
  localparam int NET_PKT_W    = 512;
  localparam int TOR_DST_W    = 3;

  typedef logic [NET_PKT_W-1:0] NetworkPacketInternal;
  typedef logic [TOR_DST_W-1:0] tor_dst_t;

  function automatic tor_dst_t tor_extract_dst(input NetworkPacketInternal pkt,
                                               input int unsigned lsb);
    return pkt[lsb +: TOR_DST_W];
  endfunction

  // Drop counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] tor_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tor_switch_scheduler_if.sv
// NIC-side bundle of the ToR switch: Tx strobes in, Rx strobes and drop counters out.
// Valid-only strobes with no backpressure: a tx_valid_in beat is accepted or dropped in the
// cycle it is presented, and an rx_valid_out beat is a 1-cycle pulse the sink must always take.
interface tor_switch_scheduler_if #(
  parameter int NUM_NICS = 4,
  parameter int PKT_W    = 512
);

  logic [NUM_NICS-1:0]       tx_valid_in;
  logic [NUM_NICS*PKT_W-1:0] tx_data_in;
  logic [NUM_NICS-1:0]       rx_valid_out;
  logic [NUM_NICS*PKT_W-1:0] rx_data_out;
  logic [NUM_NICS*32-1:0]    drop_full_cnt;
  logic [NUM_NICS*32-1:0]    drop_dst_cnt;

  modport master (
    output tx_valid_in,
    output tx_data_in,
    input  rx_valid_out,
    input  rx_data_out,
    input  drop_full_cnt,
    input  drop_dst_cnt
  );

  modport slave (
    input  tx_valid_in,
    input  tx_data_in,
    output rx_valid_out,
    output rx_data_out,
    output drop_full_cnt,
    output drop_dst_cnt
  );

endinterface

// File: rtl/tor_rr_arbiter.sv
// Round-robin arbiter for one switch output: one-hot grant starting the search at ptr,
// ptr moves just past the winner and holds when nothing is requested or grants are disabled.
module tor_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        idx = PW'((int'(ptr_q) + k) % N);
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          ptr_d      = PW'((int'(idx) + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tor_switch_scheduler.sv
// Shared ToR switch: per-source ingress FIFOs, per-output round-robin grant and registered
// Rx egress, with saturating per-source drop counters for full-buffer and bad-destination.
module tor_switch_scheduler
  import nic_defs::*;
#(
  parameter int NUM_NICS   = 4,
  parameter int PKT_W      = 512,
  parameter int DST_LSB    = 0,
  parameter int DST_W      = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_enable,
  input  logic                  cfg_allow_self,
  tor_switch_scheduler_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [PKT_W-1:0] pkt_t;
  typedef logic [AW:0]      fptr_t;
  typedef logic [DST_W-1:0] dst_t;

  pkt_t                tx_pkt   [NUM_NICS];
  dst_t                tx_dst   [NUM_NICS];
  pkt_t                head_pkt [NUM_NICS];
  dst_t                head_dst [NUM_NICS];
  logic [NUM_NICS-1:0] fifo_empty;
  logic [NUM_NICS-1:0] fifo_full;
  logic [NUM_NICS-1:0] dst_bad;
  logic [NUM_NICS-1:0] push;
  logic [NUM_NICS-1:0] pop;
  logic [NUM_NICS-1:0] req [NUM_NICS];
  logic [NUM_NICS-1:0] gnt [NUM_NICS];

  fptr_t               wr_ptr_q [NUM_NICS];
  fptr_t               wr_ptr_d [NUM_NICS];
  fptr_t               rd_ptr_q [NUM_NICS];
  fptr_t               rd_ptr_d [NUM_NICS];
  pkt_t                fifo_mem_q [NUM_NICS][FIFO_DEPTH];
  logic [31:0]         drop_full_cnt_q [NUM_NICS];
  logic [31:0]         drop_full_cnt_d [NUM_NICS];
  logic [31:0]         drop_dst_cnt_q  [NUM_NICS];
  logic [31:0]         drop_dst_cnt_d  [NUM_NICS];
  logic [NUM_NICS-1:0] rx_valid_q;
  logic [NUM_NICS-1:0] rx_valid_d;
  pkt_t                rx_data_q [NUM_NICS];
  pkt_t                rx_data_d [NUM_NICS];

  // Ingress classification; fullness uses the registered count, so a full FIFO drops even
  // when its head is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_NICS; i++) begin
      tx_pkt[i]     = bus.tx_data_in[i*PKT_W +: PKT_W];
      tx_dst[i]     = tx_pkt[i][DST_LSB +: DST_W];
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (fptr_t'(wr_ptr_q[i] - rd_ptr_q[i]) == fptr_t'(FIFO_DEPTH));
      dst_bad[i]    = (int'(tx_dst[i]) >= NUM_NICS) ||
                      ((int'(tx_dst[i]) == i) && !cfg_allow_self);
      push[i]       = bus.tx_valid_in[i] && !dst_bad[i] && !fifo_full[i];
      head_pkt[i]   = fifo_mem_q[i][rd_ptr_q[i][AW-1:0]];
      head_dst[i]   = head_pkt[i][DST_LSB +: DST_W];
    end
  end

  // Each non-empty source asks for exactly one output: the destination of its head entry.
  always_comb begin
    for (int j = 0; j < NUM_NICS; j++) begin
      req[j] = '0;
      for (int i = 0; i < NUM_NICS; i++) begin
        req[j][i] = !fifo_empty[i] && (int'(head_dst[i]) == j);
      end
    end
  end

  for (genvar j = 0; j < NUM_NICS; j++) begin : g_out
    tor_rr_arbiter #(
      .N (NUM_NICS)
    ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (cfg_enable),
      .req_i   (req[j]),
      .gnt_o   (gnt[j])
    );
  end

  always_comb begin
    pop        = '0;
    rx_valid_d = '0;
    for (int j = 0; j < NUM_NICS; j++) begin
      rx_data_d[j] = rx_data_q[j];
      for (int i = 0; i < NUM_NICS; i++) begin
        if (gnt[j][i]) begin
          pop[i]        = 1'b1;
          rx_valid_d[j] = 1'b1;
          rx_data_d[j]  = head_pkt[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_NICS; i++) begin
      wr_ptr_d[i]        = wr_ptr_q[i] + fptr_t'(push[i]);
      rd_ptr_d[i]        = rd_ptr_q[i] + fptr_t'(pop[i]);
      drop_dst_cnt_d[i]  = drop_dst_cnt_q[i];
      drop_full_cnt_d[i] = drop_full_cnt_q[i];
      if (bus.tx_valid_in[i] && dst_bad[i]) begin
        drop_dst_cnt_d[i] = tor_sat_inc(drop_dst_cnt_q[i]);
      end else if (bus.tx_valid_in[i] && fifo_full[i]) begin
        drop_full_cnt_d[i] = tor_sat_inc(drop_full_cnt_q[i]);
      end
    end
  end

  // Storage array carries no reset: emptiness is defined purely by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NICS; i++) begin
      if (push[i]) begin
        fifo_mem_q[i][wr_ptr_q[i][AW-1:0]] <= tx_pkt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '{default: '0};
      rd_ptr_q        <= '{default: '0};
      drop_full_cnt_q <= '{default: '0};
      drop_dst_cnt_q  <= '{default: '0};
      rx_data_q       <= '{default: '0};
      rx_valid_q      <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      drop_full_cnt_q <= drop_full_cnt_d;
      drop_dst_cnt_q  <= drop_dst_cnt_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
    end
  end

  assign bus.rx_valid_out = rx_valid_q;

  for (genvar j = 0; j < NUM_NICS; j++) begin : g_pack
    assign bus.rx_data_out[j*PKT_W +: PKT_W] = rx_data_q[j];
    assign bus.drop_full_cnt[j*32 +: 32]     = drop_full_cnt_q[j];
    assign bus.drop_dst_cnt[j*32 +: 32]      = drop_dst_cnt_q[j];
  end

endmodule

// File: tb/tb_tor_switch_scheduler.sv
// Bench for tor_switch_scheduler: directed scenarios plus random all-to-all traffic, all
// deliveries checked against a per-source expected-queue model of the switch.
module tb_tor_switch_scheduler;

  localparam int NUM_NICS    = 4;
  localparam int PKT_W       = 512;
  localparam int DST_W       = 3;
  localparam int FIFO_DEPTH  = 8;
  localparam int RAND_CYCLES = 10000;

  typedef logic [PKT_W-1:0] pkt_t;

  logic clk            = 1'b0;
  logic reset_n        = 1'b0;
  logic cfg_enable     = 1'b0;
  logic cfg_allow_self = 1'b0;

  tor_switch_scheduler_if #(.NUM_NICS(NUM_NICS), .PKT_W(PKT_W)) bus ();

  tor_switch_scheduler #(
    .NUM_NICS   (NUM_NICS),
    .PKT_W      (PKT_W),
    .DST_LSB    (0),
    .DST_W      (DST_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_enable     (cfg_enable),
    .cfg_allow_self (cfg_allow_self),
    .bus            (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int   n_checks = 0;
  int   n_errors = 0;
  pkt_t exp_q [NUM_NICS][$];
  int   seen_src [NUM_NICS][$];
  int   sent [NUM_NICS];
  int   delivered [NUM_NICS];
  int   m_drop_dst [NUM_NICS];
  int   m_drop_full [NUM_NICS];
  int   seq_no [NUM_NICS];
  logic en_at_edge;

  task automatic check(input string tag, input pkt_t got, input pkt_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_NICS; i++) begin
      exp_q[i].delete();
      seen_src[i].delete();
      sent[i]        = 0;
      delivered[i]   = 0;
      m_drop_dst[i]  = 0;
      m_drop_full[i] = 0;
    end
  endtask

  // Accept/drop rules applied to the packets presented this cycle; an entry stays in
  // exp_q until it is seen on Rx, so exp_q size is the buffer occupancy at the edge.
  task automatic model_ingress();
    pkt_t p;
    int   dst;
    for (int i = 0; i < NUM_NICS; i++) begin
      if (bus.tx_valid_in[i]) begin
        p   = bus.tx_data_in[i*PKT_W +: PKT_W];
        dst = int'(p[DST_W-1:0]);
        sent[i]++;
        if (dst >= NUM_NICS || (dst == i && !cfg_allow_self)) m_drop_dst[i]++;
        else if (exp_q[i].size() == FIFO_DEPTH)                m_drop_full[i]++;
        else                                                   exp_q[i].push_back(p);
      end
    end
  endtask

  task automatic observe();
    pkt_t p;
    int   src;
    logic known;
    if (!en_at_edge) check("rx_idle_when_disabled", pkt_t'(bus.rx_valid_out), '0);
    for (int j = 0; j < NUM_NICS; j++) begin
      if (bus.rx_valid_out[j]) begin
        p     = bus.rx_data_out[j*PKT_W +: PKT_W];
        src   = int'(p[7:4]);
        known = 1'b0;
        if (src < NUM_NICS) known = (exp_q[src].size() > 0);
        check("rx_dst", pkt_t'(p[DST_W-1:0]), pkt_t'(j));
        check("rx_known_src", pkt_t'(known), pkt_t'(1));
        if (known) begin
          check("rx_order", p, exp_q[src].pop_front());
          delivered[src]++;
          seen_src[j].push_back(src);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic pkt_t make_pkt(input int src, input int dst);
    pkt_t p;
    for (int k = 0; k < PKT_W/32; k++) p[k*32 +: 32] = $urandom;
    p[DST_W-1:0] = dst[DST_W-1:0];
    p[7:4]       = src[3:0];
    p[39:8]      = seq_no[src];
    seq_no[src]++;
    return p;
  endfunction

  task automatic drive(input int i, input pkt_t p);
    bus.tx_valid_in[i]               = 1'b1;
    bus.tx_data_in[i*PKT_W +: PKT_W] = p;
  endtask

  task automatic clear_tx();
    bus.tx_valid_in = '0;
  endtask

  task automatic tick();
    model_ingress();
    en_at_edge = cfg_enable;
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic do_reset();
    clear_tx();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [31:0] full_cnt(input int i);
    return bus.drop_full_cnt[i*32 +: 32];
  endfunction

  function automatic logic [31:0] dst_cnt(input int i);
    return bus.drop_dst_cnt[i*32 +: 32];
  endfunction

  function automatic int total_seen();
    int n = 0;
    for (int j = 0; j < NUM_NICS; j++) n += seen_src[j].size();
    return n;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    pkt_t p;
    int   t2_order [3] = '{0, 1, 3};
    int   dst;

    bus.tx_valid_in = '0;
    bus.tx_data_in  = '0;
    for (int i = 0; i < NUM_NICS; i++) seq_no[i] = 0;
    do_reset();

    // Reset state
    check("rst_rx_valid", pkt_t'(bus.rx_valid_out), '0);
    check("rst_rx_data0", bus.rx_data_out[0 +: PKT_W], '0);
    check("rst_full_cnt", pkt_t'(bus.drop_full_cnt), '0);
    check("rst_dst_cnt", pkt_t'(bus.drop_dst_cnt), '0);

    // 1: single packet latency
    cfg_enable = 1'b1;
    p = make_pkt(0, 2);
    drive(0, p);
    tick();
    clear_tx();
    check("t1_no_valid_t1", pkt_t'(bus.rx_valid_out), '0);
    tick();
    check("t1_valid_t2", pkt_t'(bus.rx_valid_out), pkt_t'(4'b0100));
    check("t1_data_t2", bus.rx_data_out[2*PKT_W +: PKT_W], p);
    tick();
    check("t1_pulse_end", pkt_t'(bus.rx_valid_out), '0);
    check("t1_data_hold", bus.rx_data_out[2*PKT_W +: PKT_W], p);

    // 2: three sources contend for output 2
    do_reset();
    cfg_enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(0, make_pkt(0, 2));
      drive(1, make_pkt(1, 2));
      drive(3, make_pkt(3, 2));
      tick();
    end
    clear_tx();
    repeat (12) tick();
    check("t2_count", pkt_t'(seen_src[2].size()), pkt_t'(9));
    for (int k = 0; k < seen_src[2].size() && k < 9; k++)
      check("t2_rr_order", pkt_t'(seen_src[2][k]), pkt_t'(t2_order[k % 3]));
    check("t2_no_full_drop", pkt_t'(bus.drop_full_cnt), '0);
    check("t2_no_dst_drop", pkt_t'(bus.drop_dst_cnt), '0);

    // 3: disabled scheduler fills then drops, enable drains in order
    do_reset();
    cfg_enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(1, make_pkt(1, 0));
      tick();
    end
    clear_tx();
    tick();
    check("t3_full_drops", pkt_t'(full_cnt(1)), pkt_t'(2));
    check("t3_none_out", pkt_t'(total_seen()), '0);
    cfg_enable = 1'b1;
    repeat (12) tick();
    check("t3_delivered", pkt_t'(seen_src[0].size()), pkt_t'(8));
    check("t3_full_drops_after", pkt_t'(full_cnt(1)), pkt_t'(2));

    // 4: bad and self destinations
    do_reset();
    cfg_enable     = 1'b1;
    cfg_allow_self = 1'b0;
    drive(2, make_pkt(2, 5));
    tick();
    drive(2, make_pkt(2, 2));
    tick();
    clear_tx();
    repeat (3) tick();
    check("t4_dst_drops", pkt_t'(dst_cnt(2)), pkt_t'(2));
    check("t4_none_out", pkt_t'(total_seen()), '0);
    cfg_allow_self = 1'b1;
    drive(2, make_pkt(2, 2));
    tick();
    clear_tx();
    repeat (3) tick();
    check("t4_self_delivered", pkt_t'(seen_src[2].size()), pkt_t'(1));
    check("t4_dst_drops_after", pkt_t'(dst_cnt(2)), pkt_t'(2));
    cfg_allow_self = 1'b0;

    // 5: reset in the middle of traffic
    do_reset();
    cfg_enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NUM_NICS; i++) drive(i, make_pkt(i, (i + 1) % NUM_NICS));
      tick();
    end
    clear_tx();
    drive(0, make_pkt(0, 6));
    tick();
    clear_tx();
    check("t5_pre_dst_drop", pkt_t'(dst_cnt(0)), pkt_t'(1));
    cfg_enable = 1'b1;
    tick();
    check("t5_pre_active", pkt_t'(bus.rx_valid_out), pkt_t'(4'b1111));
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", pkt_t'(bus.rx_valid_out), '0);
    for (int j = 0; j < NUM_NICS; j++)
      check("t5_rst_data", bus.rx_data_out[j*PKT_W +: PKT_W], '0);
    check("t5_rst_full_cnt", pkt_t'(bus.drop_full_cnt), '0);
    check("t5_rst_dst_cnt", pkt_t'(bus.drop_dst_cnt), '0);
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (10) tick();
    check("t5_nothing_after", pkt_t'(total_seen()), '0);

    // 6: random all-to-all traffic
    do_reset();
    cfg_enable     = 1'b1;
    cfg_allow_self = 1'b0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      clear_tx();
      for (int i = 0; i < NUM_NICS; i++) begin
        if ($urandom_range(0, 99) < 45) begin
          dst = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 7))
                                             : int'($urandom_range(0, 3));
          drive(i, make_pkt(i, dst));
        end
      end
      if (cfg_enable && $urandom_range(0, 99) < 2)        cfg_enable = 1'b0;
      else if (!cfg_enable && $urandom_range(0, 99) < 10) cfg_enable = 1'b1;
      if ($urandom_range(0, 255) == 0) cfg_allow_self = ~cfg_allow_self;
      tick();
    end
    clear_tx();
    cfg_enable = 1'b1;
    repeat (100) tick();
    for (int i = 0; i < NUM_NICS; i++) begin
      check("t6_full_cnt", pkt_t'(full_cnt(i)), pkt_t'(m_drop_full[i]));
      check("t6_dst_cnt", pkt_t'(dst_cnt(i)), pkt_t'(m_drop_dst[i]));
      check("t6_drained", pkt_t'(exp_q[i].size()), '0);
      check("t6_conserve", pkt_t'(delivered[i] + int'(full_cnt(i)) + int'(dst_cnt(i))),
            pkt_t'(sent[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
